// File: rtl/rank_filter_if.sv
// Streaming handshake bundle for rank_filter: window/rank in, selected pixel out.
// Optional min_out/max_out members exist only when RANK_FILTER_MINMAX_EN is defined.
interface rank_filter_if #(
  parameter int DW = 8,
  parameter int N  = 9,
  parameter int RW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [N*DW-1:0] pixel_in;
  logic [RW-1:0] rank_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] pixel_out;
  logic          rank_err;
`ifdef RANK_FILTER_MINMAX_EN
  logic [DW-1:0] min_out;
  logic [DW-1:0] max_out;

  modport master (
    output in_valid, pixel_in, rank_in, out_ready,
    input  in_ready, out_valid, pixel_out, rank_err, min_out, max_out
  );
  modport slave (
    input  in_valid, pixel_in, rank_in, out_ready,
    output in_ready, out_valid, pixel_out, rank_err, min_out, max_out
  );
`else
  modport master (
    output in_valid, pixel_in, rank_in, out_ready,
    input  in_ready, out_valid, pixel_out, rank_err
  );
  modport slave (
    input  in_valid, pixel_in, rank_in, out_ready,
    output in_ready, out_valid, pixel_out, rank_err
  );
`endif
endinterface

// File: rtl/rank_filter.sv
// Three-stage rank-order filter: register window, count less/equal per element, select rank.
// Optional min/max outputs are enabled with the RANK_FILTER_MINMAX_EN macro.
module rank_filter #(
  parameter int DW = 8,
  parameter int N  = 9,
  parameter int RW = 4
) (
  input logic          clk,
  input logic          rst,
  rank_filter_if.slave bus
);
  localparam int CW = RW + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef logic [N-1:0][DW-1:0] win_t;
  typedef logic [N-1:0][CW-1:0] cnt_t;

  logic          w_en;
  logic          w_clamp;
  logic [RW-1:0] w_rank;

  win_t          r_win1;
  logic [RW-1:0] r_rank1;
  logic          r_clamp1;
  logic          r_v1;

  cnt_t          w_lt;
  cnt_t          w_eq;

  win_t          r_win2;
  cnt_t          r_lt2;
  cnt_t          r_eq2;
  logic [RW-1:0] r_rank2;
  logic          r_clamp2;
  logic          r_v2;

  logic [DW-1:0] r_pixel_out;
  logic          r_rank_err;
  logic          r_out_valid;

  // The whole pipeline advances together, so a stall at the output freezes every stage.
  assign w_en         = !r_out_valid || bus.out_ready;
  assign bus.in_ready = w_en;

  assign w_clamp = {1'b0, bus.rank_in} > LAST;
  assign w_rank  = w_clamp ? LAST[RW-1:0] : bus.rank_in;

  // Lowest-index element whose [lt, lt+eq] interval contains the requested rank.
  function automatic logic [DW-1:0] pick(input win_t win, input cnt_t lt, input cnt_t eq,
                                         input logic [CW-1:0] rank);
    logic found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && lt[i] <= rank && rank <= lt[i] + eq[i]) begin
        pick  = win[i];
        found = 1'b1;
      end
    end
  endfunction

  // NOTE: every always_comb output gets a default before any conditional update,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    w_lt = '0;
    w_eq = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j != i) begin
          if (r_win1[j] <  r_win1[i]) w_lt[i] = w_lt[i] + CW'(1);
          if (r_win1[j] == r_win1[i]) w_eq[i] = w_eq[i] + CW'(1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all stages sample
  // the pre-edge values of one another.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win1   <= '0;
      r_rank1  <= '0;
      r_clamp1 <= 1'b0;
      r_v1     <= 1'b0;
    end else if (w_en) begin
      r_win1   <= bus.pixel_in;
      r_rank1  <= w_rank;
      r_clamp1 <= w_clamp;
      r_v1     <= bus.in_valid;
    end
  end

  // NOTE: the window and count arrays are plain flops here, not RAM, so they
  // are cleared on reset like any other data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win2   <= '0;
      r_lt2    <= '0;
      r_eq2    <= '0;
      r_rank2  <= '0;
      r_clamp2 <= 1'b0;
      r_v2     <= 1'b0;
    end else if (w_en) begin
      r_win2   <= r_win1;
      r_lt2    <= w_lt;
      r_eq2    <= w_eq;
      r_rank2  <= r_rank1;
      r_clamp2 <= r_clamp1;
      r_v2     <= r_v1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pixel_out <= '0;
      r_rank_err  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_en) begin
      r_pixel_out <= pick(r_win2, r_lt2, r_eq2, {1'b0, r_rank2});
      r_rank_err  <= r_clamp2;
      r_out_valid <= r_v2;
    end
  end

  assign bus.pixel_out = r_pixel_out;
  assign bus.rank_err  = r_rank_err;
  assign bus.out_valid = r_out_valid;

`ifdef RANK_FILTER_MINMAX_EN
  logic [DW-1:0] r_min_out;
  logic [DW-1:0] r_max_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_min_out <= '0;
      r_max_out <= '0;
    end else if (w_en) begin
      r_min_out <= pick(r_win2, r_lt2, r_eq2, '0);
      r_max_out <= pick(r_win2, r_lt2, r_eq2, LAST);
    end
  end

  assign bus.min_out = r_min_out;
  assign bus.max_out = r_max_out;
`endif
endmodule

// File: tb/tb_rank_filter.sv
// Scoreboard bench for rank_filter: a driver pushes expected results, a monitor pops and compares.
module tb_rank_filter;
  localparam int DW = 8;
  localparam int N  = 9;
  localparam int RW = 4;

  typedef int vals_t[N];
  typedef struct {
    logic [DW-1:0] pix;
    logic          err;
    logic [DW-1:0] mn;
    logic [DW-1:0] mx;
    int            acc;
    bit            lat;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;
  exp_t q[$];

  rank_filter_if #(.DW(DW), .N(N), .RW(RW)) bus ();

  rank_filter #(.DW(DW), .N(N), .RW(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N*DW-1:0] pack(input vals_t v);
    logic [N*DW-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[i*DW +: DW] = DW'(v[i]);
    return p;
  endfunction

  // Drives one window until accepted; the expected result goes to the scoreboard at acceptance.
  task automatic send(input vals_t v, input int rank, input int exp_pix, input bit exp_err,
                      input bit lat);
    exp_t e;
    bit   acc;
    int   t;
    e.pix = DW'(exp_pix);
    e.err = exp_err;
    e.lat = lat;
    e.mn  = DW'(v[0]);
    e.mx  = DW'(v[0]);
    for (int i = 1; i < N; i++) begin
      if (v[i] < int'(e.mn)) e.mn = DW'(v[i]);
      if (v[i] > int'(e.mx)) e.mx = DW'(v[i]);
    end
    bus.in_valid = 1'b1;
    bus.pixel_in = pack(v);
    bus.rank_in  = RW'(rank);
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 30) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.acc = cyc;
        q.push_back(e);
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) check("accept_timeout", 32'(acc), 1);
    bus.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_output actual=%0d expected=none (cycle %0d)", bus.pixel_out, cyc);
      end else if (bus.out_ready) begin
        exp_t e;
        e = q.pop_front();
        check("pixel_out", 32'(bus.pixel_out), 32'(e.pix));
        check("rank_err", 32'(bus.rank_err), 32'(e.err));
        if (e.lat) check("latency", 32'(cyc - e.acc), 3);
`ifdef RANK_FILTER_MINMAX_EN
        check("min_out", 32'(bus.min_out), 32'(e.mn));
        check("max_out", 32'(bus.max_out), 32'(e.mx));
`endif
      end else begin
        check("stall_pixel", 32'(bus.pixel_out), 32'(q[0].pix));
        check("stall_err", 32'(bus.rank_err), 32'(q[0].err));
        check("stall_in_ready", 32'(bus.in_ready), 0);
      end
    end
  end

  vals_t wa = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
  vals_t wb = '{3, 3, 3, 1, 1, 7, 7, 7, 7};
  vals_t wc = '{42, 42, 42, 42, 42, 42, 42, 42, 42};
  vals_t wd = '{0, 255, 0, 255, 128, 0, 255, 128, 0};

  initial begin
    cyc      = 0;
    checks   = 0;
    failures = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.pixel_in = '0;
    bus.rank_in  = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("in_ready_in_reset", 32'(bus.in_ready), 1);
    check("out_valid_in_reset", 32'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(bus.out_valid), 0);
    check("reset_pixel_out", 32'(bus.pixel_out), 0);
    check("reset_rank_err", 32'(bus.rank_err), 0);
    check("reset_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;

    // Median, then consecutive ranks on a window with duplicates.
    send(wa, 4, 5, 1'b0, 1'b1);
    send(wb, 0, 1, 1'b0, 1'b1);
    send(wb, 2, 3, 1'b0, 1'b1);
    send(wb, 5, 7, 1'b0, 1'b1);
    send(wb, 8, 7, 1'b0, 1'b1);
    // Bubble, then clamping and extremes.
    @(posedge clk);
    #1;
    send(wa, 12, 9, 1'b1, 1'b1);
    send(wa, 15, 9, 1'b1, 1'b1);
    send(wa, 8, 9, 1'b0, 1'b1);
    send(wa, 0, 1, 1'b0, 1'b1);
    send(wc, 0, 42, 1'b0, 1'b1);
    send(wc, 4, 42, 1'b0, 1'b1);
    send(wc, 8, 42, 1'b0, 1'b1);
    send(wd, 3, 0, 1'b0, 1'b1);
    send(wd, 4, 128, 1'b0, 1'b1);
    send(wd, 6, 255, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;

    // Ten-window stream with a four-cycle downstream stall.
    fork
      begin
        for (int r = 0; r < 10; r++) send(wa, r, (r < 9) ? r + 1 : 9, r > 8, 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;

    // Reset while two windows are in flight: both are dropped.
    send(wa, 0, 1, 1'b0, 1'b0);
    send(wa, 0, 1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midreset_out_valid", 32'(bus.out_valid), 0);
    check("midreset_in_ready", 32'(bus.in_ready), 1);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send(wa, 8, 9, 1'b0, 1'b1);

    for (int t = 0; t < 50 && q.size() > 0; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
